sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter OT_DEPTH, default 4, max outstanding accepted-but-unanswered transactions; power of two, 2..8.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 inst_req, inst_wr  in  1 each  instruction master request and write flag.
REQ-005 inst_size [1:0], inst_wstrb [3:0], inst_addr [31:0], inst_wdata [31:0]  in  instruction master request fields.
REQ-006 inst_addr_ok, inst_data_ok  out  1 each; inst_rdata  out  32  instruction master responses.
REQ-007 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  data master; widths as REQ-004/005.
REQ-008 data_addr_ok, data_data_ok  out  1 each; data_rdata  out  32  data master responses.
REQ-009 out_req, out_wr  out  1; out_size  out  2; out_wstrb  out  4; out_addr, out_wdata  out  32  shared slave request.
REQ-010 out_addr_ok, out_data_ok  in  1; out_rdata  in  32  shared slave responses.
REQ-011 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-012 Request handshake: accepted in a cycle where out_req && out_addr_ok; response: one cycle with out_data_ok, in acceptance order, for reads and writes alike.
REQ-013 Owner FIFO: OT_DEPTH entries of 1 bit (0=inst, 1=data), wrap-around read/write pointers, count 0..OT_DEPTH.
REQ-014 full = (count == OT_DEPTH); empty = (count == 0).
REQ-015 Grant: combinational; fixed priority data over inst when no lock held.
REQ-016 Lock: set when out_req high and out_addr_ok low; while set, grant held on locked master regardless of other master.
REQ-017 Lock cleared on acceptance, or when locked master drops its req (grant re-arbitrated same cycle).
REQ-018 out_req = granted master's req && !full; out_wr/size/wstrb/addr/wdata = granted master's fields (data master's when neither requests).
REQ-019 inst_addr_ok = out_addr_ok && out_req && grant==inst; data_addr_ok likewise; never both high.
REQ-020 Acceptance pushes grant owner into FIFO same edge; full blocks push, no bypass even with simultaneous pop.
REQ-021 out_data_ok with !empty: pops head; routes to inst_data_ok or data_data_ok per head bit, same cycle (combinational).
REQ-022 inst_rdata and data_rdata both driven by out_rdata every cycle; only data_ok qualifies.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-024 out_data_ok with empty FIFO: no data_ok to either master, count stays 0, proto_err set.
REQ-025 Response latency through block: zero cycles; request latency: zero cycles (no registered request path).
REQ-026 No flush input; cancelled fetches are discarded by the requester, the arbiter still routes their data_ok.

Reset
REQ-027 resetn low on an edge: count=0, pointers=0, lock cleared, proto_err=0.
REQ-028 During reset: out_req=0, inst_addr_ok=0, data_addr_ok=0, inst_data_ok=0, data_data_ok=0.
REQ-029 Reset mid-operation drops all outstanding ownership; later out_data_ok for pre-reset transactions sets proto_err.

Verification
REQ-030 inst_req and data_req high same cycle, out_addr_ok=1 -> out_addr=data_addr, data_addr_ok=1, inst_addr_ok=0, FIFO head=1.
REQ-031 inst_req high, out_addr_ok=0 for 3 cycles, data_req rises cycle 2 -> out_addr stays inst_addr until accepted, then data granted.
REQ-032 Accept inst, data, inst; slave returns 3 out_data_ok with rdata 0x11,0x22,0x33 -> inst_data_ok,data_data_ok,inst_data_ok in order.
REQ-033 OT_DEPTH=4, 4 accepts, no responses -> out_req=0 on 5th request; one out_data_ok -> out_req re-asserts next cycle.
REQ-034 out_data_ok with count=0 -> no master data_ok, proto_err=1 until resetn low.
REQ-035 resetn low with count=2, then out_data_ok -> proto_err=1, no master data_ok.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave arbiter for an SRAM-like bus: data has priority, a stalled
// grant stays locked, and an owner FIFO routes in-order responses back to their master.
module sram_like_arbiter #(
    parameter int OT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [3:0]  out_wstrb,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok,
    input  logic [31:0] out_rdata,

    output logic        proto_err
);

    localparam int PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OT_DEPTH + 1);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    logic [OT_DEPTH-1:0] owner_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                lock_q;
    owner_e              lock_owner_q;

    owner_e grant;
    logic   locked_req;
    logic   grant_req;
    logic   full;
    logic   empty;
    logic   accept;
    logic   pop;
    logic   head;

    assign full  = (count_q == CNT_W'(OT_DEPTH));
    assign empty = (count_q == '0);

    assign locked_req = (lock_owner_q == OWN_DATA) ? data_req : inst_req;

    // A held lock survives only while its master keeps requesting; otherwise re-arbitrate now.
    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = OWN_DATA;
        if (lock_q && locked_req)
            grant = lock_owner_q;
        else if (data_req)
            grant = OWN_DATA;
        else if (inst_req)
            grant = OWN_INST;
    end

    assign grant_req = (grant == OWN_DATA) ? data_req : inst_req;

    assign out_req   = resetn && grant_req && !full;
    assign out_wr    = (grant == OWN_DATA) ? data_wr    : inst_wr;
    assign out_size  = (grant == OWN_DATA) ? data_size  : inst_size;
    assign out_wstrb = (grant == OWN_DATA) ? data_wstrb : inst_wstrb;
    assign out_addr  = (grant == OWN_DATA) ? data_addr  : inst_addr;
    assign out_wdata = (grant == OWN_DATA) ? data_wdata : inst_wdata;

    assign accept       = out_req && out_addr_ok;
    assign inst_addr_ok = accept && (grant == OWN_INST);
    assign data_addr_ok = accept && (grant == OWN_DATA);

    assign head         = owner_q[rd_ptr_q];
    assign pop          = resetn && out_data_ok && !empty;
    assign inst_data_ok = pop && (head == OWN_INST);
    assign data_data_ok = pop && (head == OWN_DATA);

    assign inst_rdata = out_rdata;
    assign data_rdata = out_rdata;

    // NOTE: the owner storage is not reset; the count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (accept)
            owner_q[wr_ptr_q] <= grant;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_DATA;
            proto_err    <= 1'b0;
        end else begin
            if (accept)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            // A response with nothing outstanding has no owner to go to.
            if (out_data_ok && empty)
                proto_err <= 1'b1;

            if (out_req && !out_addr_ok) begin
                lock_q       <= 1'b1;
                lock_owner_q <= grant;
            end else if (accept) begin
                lock_q <= 1'b0;
            end else if (lock_q && !locked_req) begin
                lock_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based reference model.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        out_req, out_wr;
    logic [1:0]  out_size;
    logic [3:0]  out_wstrb;
    logic [31:0] out_addr, out_wdata;
    logic        out_addr_ok, out_data_ok;
    logic [31:0] out_rdata;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    sram_like_arbiter #(.OT_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .out_req(out_req), .out_wr(out_wr), .out_size(out_size), .out_wstrb(out_wstrb),
        .out_addr(out_addr), .out_wdata(out_wdata),
        .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok), .out_rdata(out_rdata),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: inputs are driven and outputs sampled mid-low-phase.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic rst, input logic ireq, input logic dreq,
                          input logic aok, input logic dok);
        resetn      = rst;
        inst_req    = ireq;
        data_req    = dreq;
        out_addr_ok = aok;
        out_data_ok = dok;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        resetn = 1'b1;
    endtask

    typedef struct {
        logic rst;
        logic ireq, dreq, aok, dok;
        logic e_req, e_iaok, e_daok, e_idok, e_ddok, e_perr;
    } vec_t;

    vec_t vecs [19];

    // Reference model: outstanding owners in a queue (0 inst, 1 data), lock holder or -1.
    int mq[$];
    int mlock;
    bit mperr;
    int m_g;
    bit m_out_req, m_accept, m_pop;

    task automatic model_check();
        bit ireq_h, dreq_h, greq;
        int g;
        ireq_h = inst_req;
        dreq_h = data_req;
        if (mlock >= 0 && ((mlock == 1) ? dreq_h : ireq_h)) g = mlock;
        else if (dreq_h) g = 1;
        else if (ireq_h) g = 0;
        else g = 1;
        greq      = (g == 1) ? dreq_h : ireq_h;
        m_g       = g;
        m_out_req = resetn && greq && (mq.size() < DEPTH);
        m_accept  = m_out_req && out_addr_ok;
        m_pop     = resetn && out_data_ok && (mq.size() > 0);

        check("rnd out_req", out_req, m_out_req);
        check("rnd inst_addr_ok", inst_addr_ok, m_accept && g == 0);
        check("rnd data_addr_ok", data_addr_ok, m_accept && g == 1);
        check("rnd inst_data_ok", inst_data_ok, m_pop && mq.size() > 0 && mq[0] == 0);
        check("rnd data_data_ok", data_data_ok, m_pop && mq.size() > 0 && mq[0] == 1);
        check("rnd proto_err", proto_err, mperr);
        check("rnd inst_rdata", inst_rdata, out_rdata);
        check("rnd data_rdata", data_rdata, out_rdata);
        if (resetn) begin
            check("rnd out_addr", out_addr, (g == 1) ? data_addr : inst_addr);
            check("rnd out_wdata", out_wdata, (g == 1) ? data_wdata : inst_wdata);
            check("rnd out_ctl", {27'd0, out_wr, out_size, out_wstrb},
                  (g == 1) ? {27'd0, data_wr, data_size, data_wstrb}
                           : {27'd0, inst_wr, inst_size, inst_wstrb});
        end
    endtask

    task automatic model_update();
        if (!resetn) begin
            mq.delete();
            mlock = -1;
            mperr = 1'b0;
        end else begin
            if (out_data_ok && mq.size() == 0) mperr = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_accept) mq.push_back(m_g);
            if (m_out_req && !out_addr_ok) mlock = m_g;
            else if (m_accept) mlock = -1;
            else if (mlock >= 0 && !((mlock == 1) ? data_req : inst_req)) mlock = -1;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = 32'h1000_0004; inst_wdata = 32'h0;
        data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'h3;
        data_addr = 32'h2000_0008; data_wdata = 32'hdead_beef;
        out_rdata = 32'h0;
        @(negedge clk);
        do_reset();

        // Directed table: arbitration priority, fill to full, routing, empty-pop error, reset.
        for (int i = 0; i < 19; i++) begin
            set_in(vecs[i].rst, vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok);
            #1;
            check($sformatf("vec%0d out_req", i), out_req, vecs[i].e_req);
            check($sformatf("vec%0d inst_addr_ok", i), inst_addr_ok, vecs[i].e_iaok);
            check($sformatf("vec%0d data_addr_ok", i), data_addr_ok, vecs[i].e_daok);
            check($sformatf("vec%0d inst_data_ok", i), inst_data_ok, vecs[i].e_idok);
            check($sformatf("vec%0d data_data_ok", i), data_data_ok, vecs[i].e_ddok);
            check($sformatf("vec%0d proto_err", i), proto_err, vecs[i].e_perr);
            if (i == 2)
                check("vec2 out_addr", out_addr, data_addr);
            tick();
        end

        // Stalled inst grant stays locked while data arrives, then data wins.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("lock c1 out_addr", out_addr, inst_addr);
        check("lock c1 out_req", out_req, 1'b1);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        check("lock c2 out_addr", out_addr, inst_addr);
        tick();
        #1;
        check("lock c3 out_addr", out_addr, inst_addr);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        check("lock c4 out_addr", out_addr, inst_addr);
        check("lock c4 inst_addr_ok", inst_addr_ok, 1'b1);
        check("lock c4 data_addr_ok", data_addr_ok, 1'b0);
        tick();
        #1;
        check("lock c5 out_addr", out_addr, data_addr);
        check("lock c5 data_addr_ok", data_addr_ok, 1'b1);
        check("lock c5 inst_addr_ok", inst_addr_ok, 1'b0);
        tick();

        // In-order response routing with read data passthrough.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        check("order acc0 inst", inst_addr_ok, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); #1;
        check("order acc1 data", data_addr_ok, 1'b1);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); #1;
        check("order acc2 inst", inst_addr_ok, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            out_rdata = 32'h11 * (k + 1);
            #1;
            check($sformatf("order rsp%0d inst_data_ok", k), inst_data_ok, (k != 1));
            check($sformatf("order rsp%0d data_data_ok", k), data_data_ok, (k == 1));
            check($sformatf("order rsp%0d rdata", k),
                  (k == 1) ? data_rdata : inst_rdata, 32'h11 * (k + 1));
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("order proto_err", proto_err, 1'b0);

        // Reset with two outstanding: the late response belongs to nobody.
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); #1;
        tick(); tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); #1;
        check("rst mid out_req", out_req, 1'b0);
        check("rst mid data_addr_ok", data_addr_ok, 1'b0);
        check("rst mid data_data_ok", data_data_ok, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        check("rst late data_data_ok", data_data_ok, 1'b0);
        check("rst late inst_data_ok", inst_data_ok, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("rst late proto_err", proto_err, 1'b1);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        mlock = -1;
        mperr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            resetn      = ($urandom_range(0, 79) != 0);
            inst_req    = ($urandom_range(0, 2) != 0);
            data_req    = ($urandom_range(0, 1) != 0);
            out_addr_ok = ($urandom_range(0, 1) != 0);
            out_data_ok = (mq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 29) == 0);
            inst_wr     = 1'($urandom);
            data_wr     = 1'($urandom);
            inst_size   = 2'($urandom);
            data_size   = 2'($urandom);
            inst_wstrb  = 4'($urandom);
            data_wstrb  = 4'($urandom);
            inst_addr   = $urandom;
            data_addr   = $urandom;
            inst_wdata  = $urandom;
            data_wdata  = $urandom;
            out_rdata   = $urandom;
            #1;
            model_check();
            tick();
            model_update();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
